vio_route_tx: RTL
=================

Name: vio_route_tx

Overview:
- Per-region transmit-side route tagger. Sits between a vFPGA's user output stream and the `data_dtu_sink` port of the vio switch.
- Latches the region's configured 14-bit route at start-of-packet and presents it on `route_in` for the whole packet, so the switch's tdest decode stays stable across beats.
- Registers the stream through a 2-entry skid buffer.
- Discards packets sent while no valid route is configured, and keeps packet, beat and drop counters.

Parameters:
- DATA_BITS, AXI_DATA_BITS (512): stream data width.
- ID_BITS, PID_BITS (6): tid width.
- ROUTE_BITS, 14: route/tdest width.
- CNT_BITS, 32: width of the statistics counters.

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- route_cfg  in  ROUTE_BITS  route from the region's control registers.
- route_cfg_valid  in  1  route_cfg is programmed and usable.
- s_tvalid/s_tready  in/out  1  user stream handshake.
- s_tdata  in  DATA_BITS  user data.
- s_tkeep  in  DATA_BITS/8  user byte enables.
- s_tlast  in  1  user end of packet.
- s_tid  in  ID_BITS  user tid.
- m_tvalid/m_tready  out/in  1  stream handshake toward the switch.
- m_tdata, m_tkeep, m_tlast, m_tid  out  as above  stream toward the switch.
- route_in  out  ROUTE_BITS  per-packet route (switch tdest).
- pkt_cnt  out  CNT_BITS  packets forwarded.
- beat_cnt  out  CNT_BITS  beats forwarded.
- drop_cnt  out  CNT_BITS  packets dropped.
- busy  out  1  a packet is in progress on the input side.

Behaviour:
- Reset: synchronous, active-high, on `aclk`; takes effect on the first rising edge with areset=1. All outputs go to 0 (m_tvalid=0, s_tready=0 while areset=1, route_in=0, all counters=0, busy=0), the skid buffer empties, and the FSM goes to IDLE. Reset mid-packet abandons the packet; the next accepted beat is treated as SOP.
- The input FSM has three states: IDLE, FWD, DROP.
  - IDLE: on an accepted s beat (s_tvalid&&s_tready):
    - If route_cfg_valid=1: latch route_cfg into route_hold and push the beat. Go to FWD if tlast=0, otherwise stay IDLE.
    - If route_cfg_valid=0: discard the beat. Go to DROP if tlast=0; if tlast=1, drop_cnt++ and stay IDLE.
  - FWD: push each accepted beat; return to IDLE on tlast.
  - DROP: s_tready=1 unconditionally, beats are discarded; on tlast, drop_cnt++ and return to IDLE.
- A change to route_cfg or route_cfg_valid mid-packet has no effect until the next SOP.
- busy=1 in FWD or DROP.
- Skid buffer: two entries, each holding data, keep, last, tid and route.
  - s_tready = !areset && (DROP || entries<2).
  - Output comes from the head entry; m_tvalid = entries>0.
  - route_in = head entry's route while m_tvalid=1; otherwise it holds its last value (0 after reset).
  - Simultaneous push and pop keeps the count unchanged.
  - Latency s→m is 1 cycle when m_tready=1; sustained throughput is 1 beat/cycle.
  - Full (2 entries, m_tready=0): s_tready=0 and no beat is lost.
  - A tlast=1 beat on SOP forms a 1-beat packet.
- Counters update on output handshakes (m_tvalid&&m_tready): beat_cnt++ every beat, pkt_cnt++ when m_tlast=1. Counters wrap modulo 2^CNT_BITS.
- Output payload (tdata/tkeep/tlast/tid) is stable while m_tvalid=1 and m_tready=0 (AXI4-Stream rule).

Decomposition:
- Shared package lynxTypes provides AXI_DATA_BITS and PID_BITS.
- Add the following to lynxTypes:
  - ROUTE_BITS=14.
  - typedef route_t (logic [13:0]).
  - packed struct vio_beat_t {data, keep, last, tid, route}.
- One sub-module: vio_skid_buf, a 2-entry register FIFO of vio_beat_t with valid/ready on both sides. The FSM and counters stay in the top level.

Test Plan:
- route_cfg=14'h1BFC, valid=1, 4-beat packet, m_tready=1 → 4 beats out, the first one cycle after input; route_in=14'h1BFC on all 4; pkt_cnt=1, beat_cnt=4.
- route_cfg changed to 14'h0AFC after beat 2 of a 4-beat packet → beats 3–4 still carry 14'h1BFC; the next packet carries 14'h0AFC.
- route_cfg_valid=0, 3-beat packet → s_tready=1 throughout, m_tvalid=0, drop_cnt=1. A following valid packet is forwarded normally.
- m_tready=0 with 3 beats offered → exactly 2 accepted, then s_tready=0. After m_tready is released, all 3 beats appear in order with data intact.
- Back-to-back 1-beat packets with alternating route_cfg 14'h0 / 14'h3FFF → each output beat carries its own route; pkt_cnt=beat_cnt.
- areset=1 after beat 2 of 5, then new 2-beat packet → all outputs 0 during reset; the new packet is forwarded with a fresh route; counters reflect only post-reset traffic.

Source files
------------

// File: rtl/lynxTypes.sv
// Shared stream types for the vio fabric: widths, the per-beat record carried
// through the transmit skid buffer, and the route tagger input FSM states.
package lynxTypes;

   localparam int AXI_DATA_BITS = 512;
   localparam int PID_BITS      = 6;
   localparam int ROUTE_BITS    = 14;

   typedef logic [ROUTE_BITS-1:0] route_t;

   typedef struct packed {
      logic [AXI_DATA_BITS-1:0]   data;
      logic [AXI_DATA_BITS/8-1:0] keep;
      logic                       last;
      logic [PID_BITS-1:0]        tid;
      route_t                     route;
   } vio_beat_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } vio_tx_state_t;

endpackage

// File: rtl/vio_skid_buf.sv
// Two-entry register FIFO with valid/ready on both sides. Slot 0 is always the
// head, so the read side is driven straight from a register.
module vio_skid_buf
   import lynxTypes::*;
#(
   parameter type beat_t = vio_beat_t
) (
   input  logic  aclk,
   input  logic  areset,
   input  beat_t wr_data,
   input  logic  wr_valid,
   output logic  wr_ready,
   output beat_t rd_data,
   output logic  rd_valid,
   input  logic  rd_ready
);

   beat_t      slot_reg [2];
   logic [1:0] count_reg;
   logic       wr;
   logic       rd;

   assign wr_ready = (count_reg != 2'd2);
   assign rd_valid = (count_reg != 2'd0);
   assign rd_data  = slot_reg[0];
   assign wr       = wr_valid && wr_ready;
   assign rd       = rd_valid && rd_ready;

   always_ff @(posedge aclk) begin
      if (areset) begin
         count_reg   <= 2'd0;
         slot_reg[0] <= '0;
         slot_reg[1] <= '0;
      end else begin
         if (rd && count_reg == 2'd2) begin
            slot_reg[0] <= slot_reg[1];
         end
         // A write lands in the head slot whenever the head is empty or leaving.
         if (wr) begin
            if (count_reg == 2'd0 || (count_reg == 2'd1 && rd)) begin
               slot_reg[0] <= wr_data;
            end else begin
               slot_reg[1] <= wr_data;
            end
         end
         count_reg <= count_reg + 2'(wr) - 2'(rd);
      end
   end

endmodule

// File: rtl/vio_route_tx.sv
// Transmit-side route tagger: stamps each packet with the route sampled at SOP,
// drops packets sent while no route is configured, and counts traffic.
module vio_route_tx #(
   parameter int DATA_BITS  = lynxTypes::AXI_DATA_BITS,
   parameter int ID_BITS    = lynxTypes::PID_BITS,
   parameter int ROUTE_BITS = 14,
   parameter int CNT_BITS   = 32
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [ROUTE_BITS-1:0]  route_cfg,
   input  logic                   route_cfg_valid,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [DATA_BITS-1:0]   s_tdata,
   input  logic [DATA_BITS/8-1:0] s_tkeep,
   input  logic                   s_tlast,
   input  logic [ID_BITS-1:0]     s_tid,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_BITS-1:0]   m_tdata,
   output logic [DATA_BITS/8-1:0] m_tkeep,
   output logic                   m_tlast,
   output logic [ID_BITS-1:0]     m_tid,
   output logic [ROUTE_BITS-1:0]  route_in,
   output logic [CNT_BITS-1:0]    pkt_cnt,
   output logic [CNT_BITS-1:0]    beat_cnt,
   output logic [CNT_BITS-1:0]    drop_cnt,
   output logic                   busy
);

   import lynxTypes::*;

   typedef struct packed {
      logic [DATA_BITS-1:0]   data;
      logic [DATA_BITS/8-1:0] keep;
      logic                   last;
      logic [ID_BITS-1:0]     tid;
      logic [ROUTE_BITS-1:0]  route;
   } beat_t;

   vio_tx_state_t         state_reg, state_next;
   logic [ROUTE_BITS-1:0] route_hold_reg;
   logic [ROUTE_BITS-1:0] route_last_reg;
   logic [CNT_BITS-1:0]   pkt_cnt_reg, beat_cnt_reg, drop_cnt_reg;

   logic  accept;
   logic  push;
   logic  route_latch;
   logic  drop_inc;
   logic  buf_wr_ready;
   beat_t wr_beat;
   beat_t head_beat;

   assign s_tready = !areset && (state_reg == DROP || buf_wr_ready);
   assign accept   = s_tvalid && s_tready;

   always_comb begin
      state_next  = state_reg;
      push        = 1'b0;
      route_latch = 1'b0;
      drop_inc    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (route_cfg_valid) begin
                  push        = 1'b1;
                  route_latch = 1'b1;
                  if (!s_tlast) state_next = FWD;
               end else if (s_tlast) begin
                  drop_inc = 1'b1;
               end else begin
                  state_next = DROP;
               end
            end
         end
         FWD: begin
            if (accept) begin
               push = 1'b1;
               if (s_tlast) state_next = IDLE;
            end
         end
         DROP: begin
            if (accept && s_tlast) begin
               drop_inc   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The SOP beat uses route_cfg directly; later beats reuse the held copy.
   assign wr_beat = '{data:  s_tdata,
                      keep:  s_tkeep,
                      last:  s_tlast,
                      tid:   s_tid,
                      route: route_latch ? route_cfg : route_hold_reg};

   vio_skid_buf #(
      .beat_t(beat_t)
   ) u_skid (
      .aclk     (aclk),
      .areset   (areset),
      .wr_data  (wr_beat),
      .wr_valid (push),
      .wr_ready (buf_wr_ready),
      .rd_data  (head_beat),
      .rd_valid (m_tvalid),
      .rd_ready (m_tready)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg      <= IDLE;
         route_hold_reg <= '0;
         route_last_reg <= '0;
         pkt_cnt_reg    <= '0;
         beat_cnt_reg   <= '0;
         drop_cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (route_latch) route_hold_reg <= route_cfg;
         if (m_tvalid) route_last_reg <= head_beat.route;
         if (m_tvalid && m_tready) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (head_beat.last) pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
         end
         if (drop_inc) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
   end

   assign m_tdata  = head_beat.data;
   assign m_tkeep  = head_beat.keep;
   assign m_tlast  = head_beat.last;
   assign m_tid    = head_beat.tid;
   assign route_in = m_tvalid ? head_beat.route : route_last_reg;
   assign pkt_cnt  = pkt_cnt_reg;
   assign beat_cnt = beat_cnt_reg;
   assign drop_cnt = drop_cnt_reg;
   assign busy     = (state_reg != IDLE);

endmodule
